// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake, shifts and an iterative shift-add multiply.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryflag,
  output logic             overflag,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, w_acc_nxt;
  logic [WIDTH-1:0]     r_mplier, w_res;
  logic [SHW-1:0]       r_cnt, w_sh;
  logic [WIDTH:0]       w_add, w_sub;
  logic                 w_add_v, w_sub_v, w_c, w_v, w_accept;
  assign in_ready  = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign out_valid = r_state == DONE;
  assign w_accept  = in_valid && in_ready;
  assign w_sh      = b[SHW-1:0];
  assign w_add     = {1'b0, a} + {1'b0, b};
  assign w_sub     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
  // one multiplier bit per cycle, LSB first; the multiplicand shifts left alongside
  assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (selector)
      4'd0:  begin w_res = w_add[WIDTH-1:0]; w_c = w_add[WIDTH]; w_v = w_add_v; end
      4'd1:  begin w_res = w_sub[WIDTH-1:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
      4'd2:  w_res = a ^ b;
      4'd3:  w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_v};
      4'd4:  w_res = a & b;
      4'd5:  w_res = ~(a & b);
      4'd6:  w_res = ~(a | b);
      4'd7:  w_res = a | b;
      4'd8:  w_res = a << w_sh;
      4'd9:  w_res = a >> w_sh;
      4'd10: w_res = WIDTH'($signed(a) >>> w_sh);
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      out       <= '0;
      carryflag <= 1'b0;
      overflag  <= 1'b0;
      zero      <= 1'b1;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (w_accept && selector == 4'd11) begin
      r_state  <= MUL;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_state   <= DONE;
      out       <= w_res;
      carryflag <= w_c;
      overflag  <= w_v;
      zero      <= ~|w_res;
    end else if (r_state == MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (r_cnt == SHW'(WIDTH - 1)) begin
        r_state   <= DONE;
        out       <= w_acc_nxt[WIDTH-1:0];
        carryflag <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        overflag  <= 1'b0;
        zero      <= ~|w_acc_nxt[WIDTH-1:0];
      end
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives a 32-bit and an 8-bit seq_alu against an arithmetic reference model.
module tb_seq_alu;
  logic        clk = 0, reset_n = 0, iv = 0, out_ready = 1, use8 = 0;
  logic [31:0] a = 0, b = 0;
  logic [3:0]  sel = 0;
  logic        ir32, ov32, cf32, of32, z32, ir8, ov8, cf8, of8, z8;
  logic [31:0] o32;
  logic [7:0]  o8;
  logic        x_ir, x_ov, x_cf, x_of, x_z;
  logic [31:0] x_out;
  int          ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv && !use8), .in_ready(ir32),
    .a(a), .b(b), .selector(sel), .out_valid(ov32), .out_ready(out_ready),
    .out(o32), .carryflag(cf32), .overflag(of32), .zero(z32));

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv && use8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .selector(sel), .out_valid(ov8), .out_ready(out_ready),
    .out(o8), .carryflag(cf8), .overflag(of8), .zero(z8));

  assign x_ir  = use8 ? ir8 : ir32;
  assign x_ov  = use8 ? ov8 : ov32;
  assign x_cf  = use8 ? cf8 : cf32;
  assign x_of  = use8 ? of8 : of32;
  assign x_z   = use8 ? z8  : z32;
  assign x_out = use8 ? {24'd0, o8} : o32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic [3:0] op, input longint unsigned ia,
                                input longint unsigned ib, output longint unsigned r,
                                output bit c, output bit v);
    longint unsigned m, xa, xb, p;
    longint sa, sb, t, smax, smin;
    int sh;
    m    = (64'd1 << w) - 1;
    xa   = ia & m;
    xb   = ib & m;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa   = longint'(xa) - (((xa >> (w - 1)) & 1) != 0 ? longint'(64'd1 << w) : 0);
    sb   = longint'(xb) - (((xb >> (w - 1)) & 1) != 0 ? longint'(64'd1 << w) : 0);
    sh   = int'(xb % longint'(w));
    r = 0; c = 0; v = 0;
    case (op)
      0:  begin t = sa + sb; r = (xa + xb) & m; c = ((xa + xb) >> w) != 0; v = t > smax || t < smin; end
      1:  begin t = sa - sb; r = (xa - xb) & m; c = xa >= xb; v = t > smax || t < smin; end
      2:  r = xa ^ xb;
      3:  r = (sa < sb) ? 1 : 0;
      4:  r = xa & xb;
      5:  r = ~(xa & xb) & m;
      6:  r = ~(xa | xb) & m;
      7:  r = xa | xb;
      8:  r = (xa << sh) & m;
      9:  r = xa >> sh;
      10: r = longint'(sa >>> sh) & m;
      11: begin p = xa * xb; r = p & m; c = (p >> w) != 0; end
      default: r = 0;
    endcase
  endfunction

  // issue one op with out_ready high and check latency, result, flags and the 1-cycle valid pulse
  task automatic run(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb, input string tag);
    longint unsigned r;
    bit c, v;
    int w, n;
    w = use8 ? 8 : 32;
    model(w, op, longint'(xa), longint'(xb), r, c, v);
    a = xa; b = xb; sel = op; iv = 1; out_ready = 1;
    n = 0;
    while (!x_ir && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready"}, 64'(x_ir), 1);
    @(posedge clk); #1;
    iv = 0;
    n = 0;
    while (!x_ov && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 64'(n), 64'(op == 4'd11 ? w : 0));
    chk({tag, "_out"}, 64'(x_out), r);
    chk({tag, "_cf"}, 64'(x_cf), 64'(c));
    chk({tag, "_of"}, 64'(x_of), 64'(v));
    chk({tag, "_zero"}, 64'(x_z), 64'(r == 0));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(x_ov), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 64'(o32), 0);
    chk("rst_cf", 64'(cf32), 0);
    chk("rst_of", 64'(of32), 0);
    chk("rst_zero", 64'(z32), 1);
    chk("rst_valid", 64'(ov32), 0);
    reset_n = 1;
    #1;
    chk("rst_ready", 64'(ir32), 1);
    @(posedge clk); #1;

    run(4'd0,  32'hFFFFFFFF, 32'd1, "add_wrap");
    run(4'd1,  32'h80000000, 32'd1, "sub_ovf");
    run(4'd3,  32'hFFFFFFFF, 32'd1, "slt_neg");
    run(4'd3,  32'd1, 32'hFFFFFFFF, "slt_pos");
    run(4'd11, 32'h00010000, 32'h00010000, "mul_big");
    run(4'd11, 32'd7, 32'd6, "mul_small");
    run(4'd10, 32'h80000000, 32'd31, "sra_max");
    run(4'd13, 32'h12345678, 32'd9, "reserved");

    // back-to-back non-MUL ops with in_valid and out_ready held high
    a = 1; b = 1; sel = 0; iv = 1; out_ready = 1;
    @(posedge clk); #1;
    chk("b2b_1_out", 64'(o32), 2);
    chk("b2b_1_ready", 64'(ir32), 1);
    a = 5;
    @(posedge clk); #1;
    chk("b2b_2_out", 64'(o32), 6);
    chk("b2b_2_valid", 64'(ov32), 1);
    iv = 0;
    @(posedge clk); #1;

    // backpressure: result holds, second request waits until out_ready returns
    a = 3; b = 4; sel = 0; iv = 1; out_ready = 0;
    @(posedge clk); #1;
    chk("bp_first", 64'(o32), 7);
    a = 10; b = 20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_out", 64'(o32), 7);
      chk("bp_hold_ready", 64'(ir32), 0);
      chk("bp_hold_valid", 64'(ov32), 1);
    end
    out_ready = 1;
    #1;
    chk("bp_comb_ready", 64'(ir32), 1);
    @(posedge clk); #1;
    iv = 0;
    chk("bp_next_out", 64'(o32), 30);
    chk("bp_next_valid", 64'(ov32), 1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a multiply
    a = 32'h1234; b = 32'h55; sel = 4'd11; iv = 1;
    @(posedge clk); #1;
    iv = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_valid", 64'(ov32), 0);
    reset_n = 0;
    #1;
    chk("arst_valid", 64'(ov32), 0);
    chk("arst_out", 64'(o32), 0);
    chk("arst_zero", 64'(z32), 1);
    chk("arst_cf", 64'(cf32), 0);
    #2;
    reset_n = 1;
    #1;
    chk("arst_ready", 64'(ir32), 1);
    @(posedge clk); #1;
    run(4'd0, 32'd2, 32'd2, "post_rst_add");

    for (int i = 0; i < 30; i++)
      run(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom, "rand32");

    use8 = 1;
    run(4'd10, 32'h80, 32'd3, "w8_sra");
    run(4'd8,  32'h01, 32'd7, "w8_sll");
    run(4'd11, 32'h10, 32'h10, "w8_mul");
    run(4'd0,  32'h7F, 32'h01, "w8_add_ovf");
    for (int i = 0; i < 30; i++)
      run(4'($urandom_range(0, 15)), $urandom, $urandom, "rand8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a valid/ready handshake on both sides. It covers the existing eight-operation set (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR) with carry, overflow and zero flags, and adds shifts and an iterative shift-add multiply. It sits between the register-file read stage and writeback. Exactly one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands/selector presented
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0])
- selector  input  4  opcode
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result
- carryflag  output  1  carry / unsigned-overflow flag
- overflag  output  1  signed-overflow flag
- zero  output  1  out == 0

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12–15 reserved.
- States: IDLE, MUL, DONE.
- Accept happens on an edge where in_valid && in_ready.
  - a, b and selector are sampled only at accept.
  - in_valid is ignored while in_ready is low.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Non-MUL accept: result and flags are registered at the accept edge; state becomes DONE.
- MUL accept: the multiplicand, multiplier, accumulator and counter are loaded; state becomes MUL.
  - Each MUL cycle processes one multiplier bit, LSB first.
  - After WIDTH iterations, the state becomes DONE.
- DONE: out_valid=1. On out_ready:
  - with a simultaneous accept, start the new operation (back-to-back);
  - otherwise go to IDLE.
- Arithmetic:
  - ADD: a+b. carryflag = carry out of the MSB; overflag = signed overflow.
  - SUB: a+~b+1. carryflag=1 means no borrow; overflag = signed overflow.
  - SLT: out = {0…, (a−b)[MSB] XOR ovf}, i.e. signed a<b. carryflag=0, overflag=0.
  - Logic ops: bitwise. Flags 0.
  - SLL/SRL/SRA: shift a by b[SHW-1:0]. SRA fills with a[MSB]. Flags 0.
  - MUL: out = low WIDTH bits of the unsigned a*b. carryflag=1 iff any upper WIDTH product bit is nonzero. overflag=0.
  - Reserved opcodes: out=0, flags 0, single-cycle latency.
- zero is registered alongside out and equals (out==0) whenever out_valid.
- out and the flags hold stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous, any state including mid-MUL):
  - state → IDLE;
  - out=0, carryflag=0, overflag=0, zero=1;
  - out_valid=0, in_ready=1 once reset_n is high.
  - A partial MUL is discarded.
- Non-MUL latency: accept at edge k → out_valid=1 after edge k.
- MUL latency: accept at edge k → out_valid=1 after edge k+WIDTH.
- Throughput:
  - non-MUL: one op per cycle with out_ready held high;
  - MUL: one op per WIDTH+1 cycles.
- Backpressure: with out_ready low, DONE holds indefinitely and in_ready stays 0.
- in_ready is combinational from out_ready in DONE. No other input-to-output combinational path exists.
- MUL counter wrap: the counter runs 0..WIDTH-1, then exits. No extra iteration.

## Test plan
- ADD, WIDTH=32, a=0xFFFFFFFF, b=1, out_ready=1 → one cycle later out=0, carryflag=1, overflag=0, zero=1, out_valid pulses 1 cycle.
- SUB a=0x80000000, b=1 → out=0x7FFFFFFF, carryflag=1, overflag=1, zero=0. SLT a=0xFFFFFFFF, b=1 → out=1. SLT a=1, b=0xFFFFFFFF → out=0.
- MUL a=0x00010000, b=0x00010000 → out_valid exactly 32 cycles after accept, out=0, carryflag=1, zero=1. MUL a=7, b=6 → out=42, carryflag=0.
- Backpressure: ADD 3+4 with out_ready low for 5 cycles → out=7 held, in_ready=0, a new in_valid is not accepted. Releasing out_ready with in_valid high → the next op is accepted on the same edge.
- Reset mid-MUL: assert reset_n=0 at iteration 10 → out_valid=0, out=0, zero=1 immediately (asynchronously). After release, ADD 2+2 → out=4.
- WIDTH=8 instance: SRA a=0x80, b=3 → out=0xF0. SLL a=0x01, b=7 → out=0x80. MUL 0x10*0x10 → out=0x00, carryflag=1, latency 8.
